// File: rtl/cond_pkg.sv
// Shared condition-code and flag definitions for the conditional-execution logic.
package cond_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAGW_W = 2;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition decoder: evaluates Cond against the stored NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] Flags,
  output logic               CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      // NV is deliberately treated as always-execute
      AL, NV: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: stored NZCV flags, condition check and write gating.
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [FLAGS_W-1:0] FLAGS_RST = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic [FLAGW_W-1:0] FlagW,
  input  logic               PCS,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               NoWrite,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               CondEx,
  output logic [FLAGS_W-1:0] Flags
);

  logic upd_nz, upd_cv;

  // CondEx sees only the stored flags, so a flag-setting instruction uses its pre-update state
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign upd_nz = FlagW[FLAGW_NZ] & CondEx;
  assign upd_cv = FlagW[FLAGW_CV] & CondEx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= FLAGS_RST;
    end else begin
      if (upd_nz) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (upd_cv) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Architectural writes are squashed while reset is held
  assign PCSrc    = PCS  & CondEx & ~reset;
  assign RegWrite = RegW & CondEx & ~NoWrite & ~reset;
  assign MemWrite = MemW & CondEx & ~reset;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vectors, corner sequences and random stimulus.
module tb_cond_logic;
  import cond_pkg::*;

  localparam logic [3:0] RST_VAL = 4'b0000;

  logic       clk, reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] mflags;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;
  vec_t vecs[$];

  cond_logic #(.FLAGS_RST(RST_VAL)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: predicate family chosen by cond[3:1], inverted by cond[0]; 111x always passes
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond[3:1] == 3'b111) return 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ cond[0];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                       input logic pcs, input logic rw, input logic mw, input logic nw);
    @(negedge clk);
    Cond = c; FlagW = fw; ALUFlags = alu; PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    #1;
  endtask

  // Advance one edge and update the model's flags the way an instruction retires
  task automatic tick();
    logic       ce;
    logic [3:0] mask;
    ce   = ref_cond(Cond, mflags);
    mask = {{2{FlagW[1]}}, {2{FlagW[0]}}};
    @(posedge clk);
    if (ce && !reset) mflags = (mflags & ~mask) | (ALUFlags & mask);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] v);
    drive(AL, 2'b11, v, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic check_outputs(input string tag);
    logic ce;
    ce = ref_cond(Cond, mflags);
    check({tag, ".CondEx"},   {3'b0, CondEx},   {3'b0, ce});
    check({tag, ".PCSrc"},    {3'b0, PCSrc},    {3'b0, PCS & ce & !reset});
    check({tag, ".RegWrite"}, {3'b0, RegWrite}, {3'b0, RegW & ce & !NoWrite & !reset});
    check({tag, ".MemWrite"}, {3'b0, MemWrite}, {3'b0, MemW & ce & !reset});
  endtask

  initial begin
    reset = 1'b1; Cond = EQ; FlagW = 2'b00; ALUFlags = 4'b0000;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    mflags = RST_VAL;

    // Reset: outputs forced low, flags at reset value, no update across an edge
    #3;
    check("rst.Flags", Flags, 4'b0000);
    check("rst.CondEx", {3'b0, CondEx}, 4'b0000);
    check("rst.gated", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    drive(AL, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst.AL.CondEx", {3'b0, CondEx}, 4'b0001);
    check("rst.AL.gated", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    @(posedge clk); #1;
    check("rst.noupd", Flags, 4'b0000);
    @(negedge clk); reset = 1'b0;

    // First edge after release updates
    set_flags(4'b0101);
    check("release.upd", Flags, 4'b0101);

    // CMP then BEQ / BNE
    set_flags(4'b0000);
    drive(AL, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    check("cmp.RegWrite", {3'b0, RegWrite}, 4'b0000);
    tick();
    check("cmp.Flags", Flags, 4'b0110);
    drive(EQ, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("beq.PCSrc", {3'b0, PCSrc}, 4'b0001);
    drive(NE, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bne.PCSrc", {3'b0, PCSrc}, 4'b0000);

    // Partial update: only N,Z written
    set_flags(4'b1111);
    drive(AL, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("partial.Flags", Flags, 4'b0011);

    // Failed condition: no memory write, no flag update
    set_flags(4'b0000);
    drive(EQ, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fail.MemWrite", {3'b0, MemWrite}, 4'b0000);
    tick();
    check("fail.Flags", Flags, 4'b0000);

    // Stale flags: a flag-setting EQ sees pre-update Z
    set_flags(4'b0100);
    drive(EQ, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stale.CondEx", {3'b0, CondEx}, 4'b0001);
    tick();
    check("stale.Flags", Flags, 4'b0000);
    drive(EQ, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stale.next", {3'b0, CondEx}, 4'b0000);

    // Signed/unsigned compare table
    vecs.push_back('{GE, 4'b1001, 1'b1}); vecs.push_back('{LT, 4'b1001, 1'b0});
    vecs.push_back('{GT, 4'b1001, 1'b1}); vecs.push_back('{LE, 4'b1001, 1'b0});
    vecs.push_back('{HI, 4'b1001, 1'b0}); vecs.push_back('{LS, 4'b1001, 1'b1});
    vecs.push_back('{GE, 4'b1000, 1'b0}); vecs.push_back('{LT, 4'b1000, 1'b1});
    vecs.push_back('{GT, 4'b1000, 1'b0}); vecs.push_back('{LE, 4'b1000, 1'b1});
    vecs.push_back('{HI, 4'b1000, 1'b0}); vecs.push_back('{LS, 4'b1000, 1'b1});
    vecs.push_back('{GE, 4'b0100, 1'b1}); vecs.push_back('{LT, 4'b0100, 1'b0});
    vecs.push_back('{GT, 4'b0100, 1'b0}); vecs.push_back('{LE, 4'b0100, 1'b1});
    vecs.push_back('{HI, 4'b0100, 1'b0}); vecs.push_back('{LS, 4'b0100, 1'b1});
    vecs.push_back('{GE, 4'b0000, 1'b1}); vecs.push_back('{LT, 4'b0000, 1'b0});
    vecs.push_back('{GT, 4'b0000, 1'b1}); vecs.push_back('{LE, 4'b0000, 1'b0});
    vecs.push_back('{HI, 4'b0000, 1'b0}); vecs.push_back('{LS, 4'b0000, 1'b1});
    vecs.push_back('{HI, 4'b0010, 1'b1}); vecs.push_back('{LS, 4'b0010, 1'b0});
    foreach (vecs[i]) begin
      set_flags(vecs[i].flags);
      drive(vecs[i].cond, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d.c%b.f%b", i, vecs[i].cond, vecs[i].flags),
            {3'b0, CondEx}, {3'b0, vecs[i].exp});
    end

    // Full sweep of codes against the reference model
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check($sformatf("sweep.c%0d.f%0d", c, f), {3'b0, CondEx}, {3'b0, ref_cond(4'(c), 4'(f))});
      end
    end

    // Async reset mid-cycle: MI would pass on 1010 but fails once flags return to 0000
    set_flags(4'b1010);
    drive(MI, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; mflags = RST_VAL;
    #1;
    check("async.Flags", Flags, 4'b0000);
    #1 reset = 1'b0;
    tick();
    check("async.noupd", Flags, 4'b0000);
    set_flags(4'b1100);
    check("async.after", Flags, 4'b1100);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_outputs($sformatf("rnd%0d", i));
      tick();
      check($sformatf("rnd%0d.Flags", i), Flags, mflags);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
